// File: rtl/phase_counter.sv
// Programmable-step phase/address counter with wrap, saturate, bounce and one-shot
// run modes, a registered terminal-count pulse and a phase-offset second address.
module phase_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              start,
  input  logic [WIDTH-1:0]  offset,
  output logic [WIDTH-1:0]  count,
  output logic [WIDTH-1:0]  count2,
  output logic              dir,
  output logic              tc,
  output logic              busy
);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_BOUNCE  = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] count_reg, count_next;
  logic             dir_reg, dir_next;
  logic             tc_reg, tc_next;
  logic             busy_reg, busy_next;

  logic [WIDTH-1:0] step_ext;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             step_zero;

  assign step_ext  = WIDTH'(step);
  assign sum       = {1'b0, count_reg} + {1'b0, step_ext};
  assign carry     = sum[WIDTH];
  assign step_zero = (step_ext == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      dir_reg   <= 1'b0;
      tc_reg    <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      dir_reg   <= dir_next;
      tc_reg    <= tc_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    count_next = count_reg;
    dir_next   = dir_reg;
    busy_next  = busy_reg;
    tc_next    = 1'b0;

    if (load) begin
      count_next = load_val;
      dir_next   = 1'b0;
      busy_next  = 1'b0;
    end else if (en) begin
      // A sweep only survives while the counter stays in one-shot mode.
      if (mode_t'(mode) != MODE_ONESHOT)
        busy_next = 1'b0;

      case (mode_t'(mode))
        MODE_WRAP: begin
          count_next = sum[WIDTH-1:0];
          tc_next    = carry;
        end
        MODE_SAT: begin
          if (carry || (sum[WIDTH-1:0] == MAX_VAL)) begin
            count_next = MAX_VAL;
            tc_next    = (count_reg != MAX_VAL);
          end else begin
            count_next = sum[WIDTH-1:0];
          end
        end
        MODE_BOUNCE: begin
          // A zero step must not trip the end-stop turnaround.
          if (!step_zero) begin
            if (!dir_reg) begin
              if (sum >= {1'b0, MAX_VAL}) begin
                count_next = MAX_VAL;
                dir_next   = 1'b1;
                tc_next    = 1'b1;
              end else begin
                count_next = sum[WIDTH-1:0];
              end
            end else begin
              if (count_reg <= step_ext) begin
                count_next = '0;
                dir_next   = 1'b0;
                tc_next    = 1'b1;
              end else begin
                count_next = count_reg - step_ext;
              end
            end
          end
        end
        MODE_ONESHOT: begin
          if (!busy_reg) begin
            if (start)
              busy_next = 1'b1;
          end else if (carry) begin
            count_next = '0;
            busy_next  = 1'b0;
            tc_next    = 1'b1;
          end else begin
            count_next = sum[WIDTH-1:0];
          end
        end
      endcase
    end
  end

  assign count  = count_reg;
  assign count2 = count_reg + offset;
  assign dir    = dir_reg;
  assign tc     = tc_reg;
  assign busy   = busy_reg;

endmodule
